fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised next-generation instruction fetch stage that decouples PC sequencing from decode.
- A fetch PC drives a multi-cycle instruction memory (mem_system-style Rd/Done/err handshake, one request outstanding) and fills a DEPTH-entry instruction queue.
- Decode drains the queue through a valid/ready handshake.
- Adds what the single-entry fetch lacks: prefetch buffering, decode back-pressure, redirect with in-flight-response kill, and a sticky halt on memory error.

Parameters:
- DATA_W, 16, instruction width.
- ADDR_W, 16, PC/address width.
- DEPTH, 4, queue entries (power of two, >=2).
- INSTR_LEN, 2, PC increment per instruction, in bytes.
- RESET_PC, 0, fetch PC after reset.
- NOP_INSTR, 16'h0800, instruction presented when the queue is empty.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- redirect  in  1  branch/jump redirect request.
- redirect_addr  in  ADDR_W  redirect target.
- out_ready  in  1  decode accepts head entry.
- out_valid  out  1  head entry valid.
- out_instr  out  DATA_W  head instruction, or NOP_INSTR when empty.
- out_pc  out  ADDR_W  PC of head instruction.
- out_pc_plus  out  ADDR_W  out_pc + INSTR_LEN.
- out_err  out  1  head entry came from a memory error.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  memory read request.
- mem_data  in  DATA_W  memory read data.
- mem_done  in  1  read complete, mem_data valid.
- mem_err  in  1  read failed.
- busy  out  1  request outstanding or draining.

Reset and interface (Already decided):
- One clock, clk. Reset is synchronous and active-low on rst.
- rst low at a posedge sets: fetch_pc=RESET_PC, count=0, head/tail=0, state=IDLE, halted=0.
- After reset: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_err=0, mem_rd=0, busy=0, mem_addr=RESET_PC.
- Reset asserted mid-request abandons that request; a later mem_done is ignored in IDLE.

Behaviour:
- States: IDLE, REQ, DRAIN, HALT.
  - mem_rd=1 in REQ and DRAIN. busy = (state != IDLE).
  - mem_addr = request PC. It is latched at REQ entry and held stable until mem_done or mem_err.
- IDLE -> REQ when count_next < DEPTH and no redirect this cycle. Requested address = fetch_pc.
- REQ with mem_done:
  - Enqueue {mem_data, fetch_pc, err=0}; fetch_pc += INSTR_LEN.
  - Stay in REQ (next address latched) if count_next < DEPTH, else go to IDLE.
  - Throughput: one instruction per memory completion.
- REQ with mem_err (takes priority over mem_done):
  - Enqueue {16'b0, fetch_pc, err=1}, i.e. HALT encoding; go to HALT.
  - No further fetches until redirect or reset.
- Redirect (highest priority, any state):
  - Queue flushed (count=0) and fetch_pc := redirect_addr in the same edge.
  - The same-cycle dequeue and enqueue are discarded.
  - From REQ: a same-cycle mem_done/mem_err response is discarded and the next state is IDLE. Otherwise go to DRAIN.
  - From HALT or IDLE: go to IDLE.
- DRAIN:
  - mem_rd and mem_addr are held at the killed address.
  - On mem_done or mem_err, discard the response and go to IDLE.
  - A further redirect in DRAIN only updates fetch_pc.
- Dequeue when out_valid & out_ready & !redirect; head advances.
  - count_next = count + enq - deq.
  - Simultaneous enq/deq keeps count constant. Pointers wrap modulo DEPTH.
- out_valid = (count != 0). Head fields are combinational from the queue; out_instr = NOP_INSTR when empty.
- Full queue: no new request issues. An in-flight request always has a reserved slot, because a request issues only when count_next < DEPTH.
- Arithmetic: PC adds are ADDR_W bits, wrapping modulo 2^ADDR_W (e.g. 16'hFFFE + 2 = 16'h0000).

Decomposition:
- Shared package:
  - fetch state encodings (IDLE, REQ, DRAIN, HALT);
  - NOP_INSTR and HALT encoding constants;
  - queue entry layout {err, pc, instr}.
- One sub-module: fetch_fifo. Parametrised DEPTH x (1+ADDR_W+DATA_W), synchronous active-low rst, flush input, enq/deq, count/full/empty outputs.
- The FSM and PC logic stay in fetch_queue.

Test Plan:
1. Reset/fill: rst low 2 cycles then high; memory completes every cycle, out_ready=0.
   -> Requests at 0,2,4,6; out_valid rises with instr@0; after 4 entries mem_rd=0 and busy=0.
2. Streaming: out_ready=1, memory latency 3 cycles.
   -> out_pc sequence 0,2,4,... with no gaps or duplicates; out_pc_plus = out_pc+2.
3. Redirect in REQ before done: redirect_addr=16'h0040 while the request to 0x0006 is outstanding.
   -> Queue empties next cycle; DRAIN holds mem_addr=0x0006; its data is never dequeued; next request is 0x0040.
4. Redirect coincident with mem_done: redirect_addr=16'h0100.
   -> Returned data dropped; next state IDLE; first dequeued out_pc=0x0100.
5. mem_err on fetch 0x0008.
   -> Entry with out_instr=16'h0000, out_err=1, out_pc=0x0008; no further mem_rd; redirect to 0x0010 resumes fetching.
6. Wrap and mid-operation reset: start at 16'hFFFC with a full queue while dequeuing.
   -> out_pc FFFC, FFFE, 0000, pointers wrap correctly.
   -> rst low during REQ returns to the reset values; a stale mem_done afterwards enqueues nothing.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared state encodings, instruction constants and entry layout helpers
// for the fetch_queue instruction fetch stage.
package fetch_queue_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam logic [15:0] DEFAULT_NOP_INSTR = 16'h0800;
   localparam logic [15:0] HALT_INSTR        = 16'h0000;

   // Queue entries are packed MSB-first as {err, pc, instr}.
   function automatic int entry_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue with flush; the head entry is presented
// combinationally so decode sees it in the same cycle it becomes valid.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     enq,
   input  logic [WIDTH-1:0]         enq_data,
   input  logic                     deq,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    head_reg, tail_reg;
   logic [PW:0]      count_reg;
   logic             do_enq, do_deq;

   assign full      = (count_reg == (PW+1)'(DEPTH));
   assign empty     = (count_reg == '0);
   assign count     = count_reg;
   assign head_data = mem_reg[head_reg];
   assign do_deq    = deq && !empty;
   assign do_enq    = enq && (!full || do_deq);

   always_ff @(posedge clk) begin
      if (do_enq && !flush)
         mem_reg[tail_reg] <= enq_data;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (do_enq)
            tail_reg <= tail_reg + PW'(1);
         if (do_deq)
            head_reg <= head_reg + PW'(1);
         count_reg <= count_reg + (PW+1)'(do_enq) - (PW+1)'(do_deq);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch stage: sequences the PC against a
// one-outstanding-request memory and buffers results for decode.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                 DATA_W    = 16,
   parameter int                 ADDR_W    = 16,
   parameter int                 DEPTH     = 4,
   parameter int                 INSTR_LEN = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(DEFAULT_NOP_INSTR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_plus,
   output logic              out_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_done,
   input  logic              mem_err,
   output logic              busy
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = entry_width(ADDR_W, DATA_W);

   typedef struct packed {
      logic              err;
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
   logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
   logic [ADDR_W-1:0] pc_inc;
   logic [CW-1:0]     count, count_next;
   logic              full, empty, enq, deq, room;
   entry_t            enq_entry, head_entry;
   logic [EW-1:0]     head_bits;

   assign pc_inc     = fetch_pc_reg + ADDR_W'(INSTR_LEN);
   assign deq        = !empty && out_ready && !redirect;
   assign enq        = (state_reg == REQ) && (mem_done || mem_err) && !redirect
                       && (!full || deq);
   assign count_next = redirect ? '0 : count + CW'(enq) - CW'(deq);
   assign room       = (count_next < CW'(DEPTH));

   // An error response is recorded as the halt encoding so decode can trap on it.
   assign enq_entry.err   = mem_err;
   assign enq_entry.pc    = fetch_pc_reg;
   assign enq_entry.instr = mem_err ? DATA_W'(HALT_INSTR) : mem_data;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .enq       (enq),
      .enq_data  (enq_entry),
      .deq       (deq),
      .head_data (head_bits),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign head_entry  = entry_t'(head_bits);
   assign out_valid   = !empty;
   assign out_instr   = empty ? NOP_INSTR : head_entry.instr;
   assign out_pc      = empty ? '0 : head_entry.pc;
   assign out_err     = !empty && head_entry.err;
   assign out_pc_plus = out_pc + ADDR_W'(INSTR_LEN);

   assign mem_rd   = (state_reg == REQ) || (state_reg == DRAIN);
   assign mem_addr = req_addr_reg;
   assign busy     = (state_reg != IDLE);

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      req_addr_next = req_addr_reg;
      case (state_reg)
         IDLE: begin
            if (redirect) begin
               fetch_pc_next = redirect_addr;
            end else if (room) begin
               state_next    = REQ;
               req_addr_next = fetch_pc_reg;
            end
         end
         REQ: begin
            // A killed request still owes the memory a response unless it
            // arrives this very cycle; DRAIN absorbs it.
            if (redirect) begin
               fetch_pc_next = redirect_addr;
               state_next    = (mem_done || mem_err) ? IDLE : DRAIN;
            end else if (mem_err) begin
               state_next = HALT;
            end else if (mem_done) begin
               fetch_pc_next = pc_inc;
               if (room)
                  req_addr_next = pc_inc;
               else
                  state_next = IDLE;
            end
         end
         DRAIN: begin
            if (redirect)
               fetch_pc_next = redirect_addr;
            if (mem_done || mem_err)
               state_next = IDLE;
         end
         HALT: begin
            if (redirect) begin
               fetch_pc_next = redirect_addr;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         req_addr_reg <= RESET_PC;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         req_addr_reg <= req_addr_next;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order PC-stream model and a
// scripted memory responder.
`timescale 1ns/1ps
module tb_fetch_queue;
   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_addr = 16'h0000;
   logic        out_ready = 1'b0;
   logic        out_valid, out_err, mem_rd, busy;
   logic [15:0] out_instr, out_pc, out_pc_plus, mem_addr;
   logic [15:0] mem_data = 16'h0000;
   logic        mem_done = 1'b0;
   logic        mem_err = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   bit          auto_mem = 1'b0;
   int          latency = 1;
   int          resp_cyc = 0;
   bit          err_en = 1'b0;
   logic [15:0] err_addr = 16'h0008;

   logic [15:0] exp_pc = 16'h0000;
   bit          halted_seen = 1'b0;
   int          deq_cnt = 0;
   logic        prev_rd = 1'b0;
   logic        prev_resp = 1'b0;
   logic [15:0] prev_addr = 16'h0000;
   logic [15:0] pcp;
   bit          found;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk           (clk),
      .rst           (rst),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_pc_plus   (out_pc_plus),
      .out_err       (out_err),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .mem_done      (mem_done),
      .mem_err       (mem_err),
      .busy          (busy)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, out_valid, 1'b0);
      check({tag, "_instr"}, out_instr, NOP);
      check({tag, "_pc"},    out_pc, 16'h0000);
      check({tag, "_err"},   out_err, 1'b0);
      check({tag, "_rd"},    mem_rd, 1'b0);
      check({tag, "_busy"},  busy, 1'b0);
      check({tag, "_addr"},  mem_addr, 16'h0000);
   endtask

   // Memory responder: completes each request after 'latency' cycles of mem_rd.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (auto_mem) begin
            if (mem_rd) begin
               resp_cyc++;
               if (resp_cyc >= latency) begin
                  resp_cyc = 0;
                  mem_err  = err_en && (mem_addr == err_addr);
                  mem_done = !(err_en && (mem_addr == err_addr));
                  mem_data = mem_word(mem_addr);
               end else begin
                  mem_done = 1'b0;
                  mem_err  = 1'b0;
               end
            end else begin
               resp_cyc = 0;
               mem_done = 1'b0;
               mem_err  = 1'b0;
            end
         end else begin
            resp_cyc = 0;
         end
      end
   end

   // Model: decode must see consecutive PCs from the last reset/redirect target,
   // each carrying the memory word for that PC, and nothing after a halt entry.
   always @(negedge clk) begin
      if (!rst) begin
         exp_pc      = 16'h0000;
         halted_seen = 1'b0;
         prev_rd     = 1'b0;
      end else begin
         if (prev_rd && !prev_resp) begin
            check("mem_rd_hold", mem_rd, 1'b1);
            check("mem_addr_hold", mem_addr, prev_addr);
         end
         check("busy_when_rd", (busy || !mem_rd), 1'b1);
         if (out_valid) begin
            pcp = out_pc + 16'd2;
            check("pc_plus", out_pc_plus, pcp);
            if (out_err)
               check("halt_instr", out_instr, 16'h0000);
            else
               check("instr_data", out_instr, mem_word(out_pc));
         end else begin
            check("empty_instr", out_instr, NOP);
            check("empty_err", out_err, 1'b0);
         end
         if (redirect) begin
            exp_pc      = redirect_addr;
            halted_seen = 1'b0;
         end else if (out_valid && out_ready) begin
            check("deq_pc", out_pc, exp_pc);
            check("deq_err", out_err, (err_en && (out_pc == err_addr)));
            check("deq_after_halt", halted_seen, 1'b0);
            if (out_err)
               halted_seen = 1'b1;
            exp_pc = exp_pc + 16'd2;
            deq_cnt++;
         end
         prev_rd   = mem_rd;
         prev_resp = mem_done || mem_err;
         prev_addr = mem_addr;
      end
   end

   initial begin
      // 1: reset and fill with single-cycle memory, decode stalled
      tick();
      tick();
      check_reset_values("rst");
      latency  = 1;
      auto_mem = 1'b1;
      rst      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("fill_rd", mem_rd, 1'b1);
         check("fill_addr", mem_addr, 16'(2 * i));
      end
      tick();
      check("full_rd", mem_rd, 1'b0);
      check("full_busy", busy, 1'b0);
      check("full_valid", out_valid, 1'b1);
      check("full_pc", out_pc, 16'h0000);
      check("full_instr", out_instr, 16'hC3C3);

      // 2: streaming with 3-cycle memory
      latency   = 3;
      deq_cnt   = 0;
      out_ready = 1'b1;
      repeat (40) tick();
      check("stream_progress", (deq_cnt >= 12), 1'b1);

      // 3: redirect while the request to 0x0006 is outstanding
      out_ready = 1'b0;
      auto_mem  = 1'b0;
      mem_done  = 1'b0;
      mem_err   = 1'b0;
      rst       = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("t3_addr0", mem_addr, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         mem_done = 1'b1;
         mem_data = mem_word(mem_addr);
         tick();
      end
      mem_done = 1'b0;
      check("t3_addr6", mem_addr, 16'h0006);
      tick();
      tick();
      redirect      = 1'b1;
      redirect_addr = 16'h0040;
      tick();
      redirect = 1'b0;
      check("t3_flushed", out_valid, 1'b0);
      check("t3_drain_rd", mem_rd, 1'b1);
      check("t3_drain_busy", busy, 1'b1);
      check("t3_drain_addr", mem_addr, 16'h0006);
      tick();
      check("t3_drain_addr2", mem_addr, 16'h0006);
      mem_done = 1'b1;
      mem_data = 16'hDEAD;
      tick();
      mem_done = 1'b0;
      check("t3_idle_rd", mem_rd, 1'b0);
      check("t3_idle_busy", busy, 1'b0);
      tick();
      check("t3_req_rd", mem_rd, 1'b1);
      check("t3_req_addr", mem_addr, 16'h0040);
      mem_done = 1'b1;
      mem_data = mem_word(16'h0040);
      tick();
      mem_done = 1'b0;
      check("t3_head_pc", out_pc, 16'h0040);
      check("t3_head_instr", out_instr, 16'h83C3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 4: redirect coincident with mem_done for 0x0042
      mem_done      = 1'b1;
      mem_data      = 16'hBEEF;
      redirect      = 1'b1;
      redirect_addr = 16'h0100;
      tick();
      mem_done = 1'b0;
      redirect = 1'b0;
      check("t4_idle_rd", mem_rd, 1'b0);
      check("t4_idle_busy", busy, 1'b0);
      check("t4_empty", out_valid, 1'b0);
      tick();
      check("t4_req_addr", mem_addr, 16'h0100);
      mem_done = 1'b1;
      mem_data = mem_word(16'h0100);
      tick();
      mem_done = 1'b0;
      check("t4_head_pc", out_pc, 16'h0100);
      check("t4_head_instr", out_instr, 16'hC3C2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 5: memory error on 0x0008, then resume via redirect
      err_en        = 1'b1;
      err_addr      = 16'h0008;
      latency       = 2;
      out_ready     = 1'b1;
      redirect      = 1'b1;
      redirect_addr = 16'h0000;
      auto_mem      = 1'b1;
      tick();
      redirect = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (out_valid && out_err)
            found = 1'b1;
      end
      check("t5_err_seen", found, 1'b1);
      check("t5_err_instr", out_instr, 16'h0000);
      check("t5_err_pc", out_pc, 16'h0008);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5_halt_rd", mem_rd, 1'b0);
         check("t5_halt_busy", busy, 1'b1);
      end
      err_en        = 1'b0;
      redirect      = 1'b1;
      redirect_addr = 16'h0010;
      tick();
      redirect = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (mem_rd && mem_addr == 16'h0010)
            found = 1'b1;
      end
      check("t5_resume", found, 1'b1);
      repeat (10) tick();

      // 6: address wrap with a full queue, then reset mid-request
      out_ready     = 1'b0;
      latency       = 1;
      redirect      = 1'b1;
      redirect_addr = 16'hFFFC;
      tick();
      redirect = 1'b0;
      repeat (12) tick();
      check("t6_full_valid", out_valid, 1'b1);
      check("t6_full_rd", mem_rd, 1'b0);
      check("t6_head_pc", out_pc, 16'hFFFC);
      check("t6_head_instr", out_instr, 16'h3F3C);
      out_ready = 1'b1;
      tick();
      check("t6_pc_fffe", out_pc, 16'hFFFE);
      check("t6_plus_wrap", out_pc_plus, 16'h0000);
      tick();
      check("t6_pc_0000", out_pc, 16'h0000);
      check("t6_plus_0002", out_pc_plus, 16'h0002);
      tick();
      check("t6_pc_0002", out_pc, 16'h0002);
      repeat (12) tick();
      auto_mem = 1'b0;
      mem_done = 1'b0;
      mem_err  = 1'b0;
      tick();
      check("t6_in_req", mem_rd, 1'b1);
      out_ready = 1'b0;
      rst       = 1'b0;
      tick();
      check_reset_values("midrst");
      rst      = 1'b1;
      mem_done = 1'b1;
      mem_data = 16'hDEAD;
      tick();
      mem_done = 1'b0;
      check("t6_stale_valid", out_valid, 1'b0);
      check("t6_stale_rd", mem_rd, 1'b1);
      check("t6_stale_addr", mem_addr, 16'h0000);
      tick();
      check("t6_stale_valid2", out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
